// File: rtl/fpu_wb_stage_if.sv
// FPU writeback bundle: capture side (in_*), register-file write side (out_*),
// hazard query (chk_*) and occupancy. "slave" is the stage, "master" its environment.
interface fpu_wb_stage_if #(
  parameter int SIG_WIDTH  = 23,
  parameter int EXP_WIDTH  = 8,
  parameter int LEN        = 9,
  parameter int ADDR_WIDTH = 5
);
  localparam int DATA_W = SIG_WIDTH + EXP_WIDTH + 1;

  logic                            in_valid;
  logic                            in_ready;
  logic [LEN-1:0][DATA_W-1:0]      in_data;
  logic [LEN-1:0][DATA_W-1:0]      in_old;
  logic [LEN-1:0]                  in_predicate;
  logic [ADDR_WIDTH-1:0]           in_addr;

  logic                            out_valid;
  logic                            out_ready;
  logic [LEN-1:0][DATA_W-1:0]      out_data;
  logic [ADDR_WIDTH-1:0]           out_addr;

  logic [ADDR_WIDTH-1:0]           chk_addr;
  logic                            chk_hit;
  logic [1:0]                      count;

  modport slave (
    input  in_valid, in_data, in_old, in_predicate, in_addr,
    output in_ready,
    output out_valid, out_data, out_addr,
    input  out_ready,
    input  chk_addr,
    output chk_hit, count
  );

  modport master (
    output in_valid, in_data, in_old, in_predicate, in_addr,
    input  in_ready,
    input  out_valid, out_data, out_addr,
    output out_ready,
    output chk_addr,
    input  chk_hit, count
  );
endinterface

// File: rtl/fpu_wb_stage.sv
// FPU writeback: predicated merge into a 2-entry FIFO, 1-cycle latency, in_ready = not full (registered only).
// Optional FPU_WB_NAN_CANON_EN: NaNs on predicated lanes are replaced by the canonical quiet NaN before storage.
module fpu_wb_stage #(
  parameter int SIG_WIDTH  = 23,
  parameter int EXP_WIDTH  = 8,
  parameter int LEN        = 9,
  parameter int ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  fpu_wb_stage_if.slave    bus
);

  localparam int DATA_W = SIG_WIDTH + EXP_WIDTH + 1;

  typedef logic [LEN-1:0][DATA_W-1:0] vec_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    vec_t                  data;
  } entry_t;

`ifdef FPU_WB_NAN_CANON_EN
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
`endif

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  vec_t                  out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;

  logic   push_fire;
  logic   enq;
  logic   pop;
  vec_t   merged;
  entry_t head_next;
  logic   ent0_vld;
  logic   ent1_vld;
  logic   chk_hit_c;

  // Readiness is a function of stored occupancy only, so a pop never frees a slot in the same cycle.
  assign bus.in_ready  = rst_n && (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.count     = count_q;
  assign bus.chk_hit   = chk_hit_c;

  always_comb begin
    merged = '0;
    for (int i = 0; i < LEN; i++) begin
      if (bus.in_predicate[i]) begin
        merged[i] = bus.in_data[i];
`ifdef FPU_WB_NAN_CANON_EN
        if ((&bus.in_data[i][DATA_W-2 -: EXP_WIDTH]) && (|bus.in_data[i][SIG_WIDTH-1:0])) begin
          merged[i] = QNAN;
        end
`endif
      end else begin
        merged[i] = bus.in_old[i];
      end
    end
  end

  always_comb begin
    push_fire = bus.in_valid && bus.in_ready;
    // A fully masked result completes the handshake but has nothing to write.
    enq       = push_fire && (|bus.in_predicate);
    pop       = (count_q != 2'd0) && bus.out_ready;

    mem_d[0]  = mem_q[0];
    mem_d[1]  = mem_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (enq) begin
      mem_d[wr_ptr_q] = '{addr: bus.in_addr, data: merged};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({enq, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Output registers track whatever will be at the head after this edge.
    head_next  = mem_d[rd_ptr_d];
    out_data_d = head_next.data;
    out_addr_d = head_next.addr;
  end

  always_comb begin
    ent0_vld  = (count_q == 2'd2) || ((count_q == 2'd1) && !rd_ptr_q);
    ent1_vld  = (count_q == 2'd2) || ((count_q == 2'd1) &&  rd_ptr_q);
    chk_hit_c = (ent0_vld && (mem_q[0].addr == bus.chk_addr)) ||
                (ent1_vld && (mem_q[1].addr == bus.chk_addr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
    end
  end

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Directed bench for fpu_wb_stage: queue-based reference model checked every cycle, plus literal expectations.
module tb_fpu_wb_stage;
  localparam int SIG_WIDTH  = 23;
  localparam int EXP_WIDTH  = 8;
  localparam int LEN        = 9;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_W     = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int BUSW       = LEN * DATA_W;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUSW-1:0]       data;
  } ment_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   live = 1'b0;
  ment_t mq[$];

  fpu_wb_stage_if #(.SIG_WIDTH(SIG_WIDTH), .EXP_WIDTH(EXP_WIDTH), .LEN(LEN), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  fpu_wb_stage #(.SIG_WIDTH(SIG_WIDTH), .EXP_WIDTH(EXP_WIDTH), .LEN(LEN), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BUSW-1:0] fill(input logic [DATA_W-1:0] v);
    logic [LEN-1:0][DATA_W-1:0] r;
    for (int i = 0; i < LEN; i++) r[i] = v;
    return r;
  endfunction

  // Reference merge: predicated lanes take the FPU result, others keep the old register value.
  function automatic logic [BUSW-1:0] model_merge();
    logic [LEN-1:0][DATA_W-1:0] r;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < LEN; i++) begin
      d = bus.in_data[i];
      if (bus.in_predicate[i]) begin
`ifdef FPU_WB_NAN_CANON_EN
        if (d[30:23] == 8'hFF && d[22:0] != 23'd0) d = 32'h7FC00000;
`endif
        r[i] = d;
      end else begin
        r[i] = bus.in_old[i];
      end
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        live = 1'b1;
      end else begin
        automatic bit acc = bus.in_valid && (mq.size() != 2);
        automatic bit pl  = (mq.size() != 0) && bus.out_ready;
        if (pl) void'(mq.pop_front());
        if (acc && bus.in_predicate != '0) mq.push_back('{addr: bus.in_addr, data: model_merge()});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        automatic bit hit = 1'b0;
        foreach (mq[k]) if (mq[k].addr == bus.chk_addr) hit = 1'b1;
        check("cyc_count", BUSW'(bus.count), BUSW'(mq.size()));
        check("cyc_out_valid", BUSW'(bus.out_valid), BUSW'(mq.size() != 0));
        check("cyc_in_ready", BUSW'(bus.in_ready), BUSW'(rst_n && mq.size() != 2));
        check("cyc_chk_hit", BUSW'(bus.chk_hit), BUSW'(hit));
        if (mq.size() != 0) begin
          check("cyc_out_addr", BUSW'(bus.out_addr), BUSW'(mq[0].addr));
          check("cyc_out_data", bus.out_data, mq[0].data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] o,
                        input logic [LEN-1:0] p, input logic [ADDR_WIDTH-1:0] a);
    bus.in_valid     = v;
    bus.in_data      = fill(d);
    bus.in_old       = fill(o);
    bus.in_predicate = p;
    bus.in_addr      = a;
  endtask

  initial begin
    logic [LEN-1:0][DATA_W-1:0] exp_v;
    rst_n         = 1'b0;
    set_in(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b0;
    bus.chk_addr  = '0;
    step();
    step();

    check("rst_count", BUSW'(bus.count), BUSW'(0));
    check("rst_out_valid", BUSW'(bus.out_valid), BUSW'(0));
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_addr", BUSW'(bus.out_addr), BUSW'(0));
    check("rst_chk_hit", BUSW'(bus.chk_hit), BUSW'(0));
    check("rst_in_ready_low", BUSW'(bus.in_ready), BUSW'(0));
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", BUSW'(bus.in_ready), BUSW'(1));

    // Single push with full predicate
    set_in(1'b1, 32'h3F800000, 32'h0, 9'h1FF, 5'd3);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("single_valid", BUSW'(bus.out_valid), BUSW'(1));
    check("single_addr", BUSW'(bus.out_addr), BUSW'(3));
    check("single_data", bus.out_data, fill(32'h3F800000));
    step();
    check("single_drained", BUSW'(bus.count), BUSW'(0));

    // Predicate merge
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h40000000, 32'hBF800000, 9'b000000101, 5'd4);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < LEN; i++) exp_v[i] = 32'hBF800000;
    exp_v[0] = 32'h40000000;
    exp_v[2] = 32'h40000000;
    check("merge_data", bus.out_data, exp_v);
    bus.out_ready = 1'b1;
    step();

    // Backpressure: three pushes into a 2-deep buffer
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h0000000A, 32'h0, 9'h1FF, 5'd10);
    step();
    set_in(1'b1, 32'h0000000B, 32'h0, 9'h1FF, 5'd11);
    step();
    set_in(1'b1, 32'h0000000C, 32'h0, 9'h1FF, 5'd12);
    check("bp_full_count", BUSW'(bus.count), BUSW'(2));
    check("bp_in_ready", BUSW'(bus.in_ready), BUSW'(0));
    step();
    check("bp_hold_addr", BUSW'(bus.out_addr), BUSW'(10));
    check("bp_hold_data", bus.out_data, fill(32'h0000000A));
    bus.out_ready = 1'b1;
    step();
    check("bp_pop1_count", BUSW'(bus.count), BUSW'(1));
    check("bp_pop1_addr", BUSW'(bus.out_addr), BUSW'(11));
    check("bp_pop1_ready", BUSW'(bus.in_ready), BUSW'(1));
    step();
    bus.in_valid = 1'b0;
    check("bp_swap_count", BUSW'(bus.count), BUSW'(1));
    check("bp_swap_addr", BUSW'(bus.out_addr), BUSW'(12));
    check("bp_swap_data", bus.out_data, fill(32'h0000000C));
    step();
    check("bp_empty", BUSW'(bus.count), BUSW'(0));

    // All-zero predicate
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h12345678, 32'h0, 9'h000, 5'd9);
    #1;
    check("pz_in_ready", BUSW'(bus.in_ready), BUSW'(1));
    step();
    bus.in_valid = 1'b0;
    check("pz_count", BUSW'(bus.count), BUSW'(0));
    check("pz_out_valid", BUSW'(bus.out_valid), BUSW'(0));

    // Hazard query
    set_in(1'b1, 32'h3F000000, 32'h0, 9'h1FF, 5'd7);
    bus.chk_addr = 5'd7;
    #1;
    check("hz_not_self", BUSW'(bus.chk_hit), BUSW'(0));
    step();
    bus.in_valid = 1'b0;
    check("hz_hit", BUSW'(bus.chk_hit), BUSW'(1));
    bus.chk_addr = 5'd8;
    #1;
    check("hz_miss", BUSW'(bus.chk_hit), BUSW'(0));
    bus.chk_addr  = 5'd7;
    bus.out_ready = 1'b1;
    step();
    check("hz_popped", BUSW'(bus.chk_hit), BUSW'(0));

    // Reset with two entries buffered; handshake during reset ignored
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h11111111, 32'h0, 9'h1FF, 5'd1);
    step();
    set_in(1'b1, 32'h22222222, 32'h0, 9'h1FF, 5'd2);
    step();
    check("mr_full", BUSW'(bus.count), BUSW'(2));
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check("mr_count", BUSW'(bus.count), BUSW'(0));
    check("mr_out_valid", BUSW'(bus.out_valid), BUSW'(0));
    step();
    check("mr_stay_empty", BUSW'(bus.count), BUSW'(0));

    // NaN handling on predicated and masked lanes, infinity untouched
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'hFFC12345, 32'h11111111, 9'b000000111, 5'd5);
    bus.in_data[2] = 32'hFF800000;
    bus.in_data[3] = 32'h7F812345;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < LEN; i++) exp_v[i] = 32'h11111111;
`ifdef FPU_WB_NAN_CANON_EN
    exp_v[0] = 32'h7FC00000;
    exp_v[1] = 32'h7FC00000;
`else
    exp_v[0] = 32'hFFC12345;
    exp_v[1] = 32'hFFC12345;
`endif
    exp_v[2] = 32'hFF800000;
    check("nan_data", bus.out_data, exp_v);
    bus.out_ready = 1'b1;
    step();

    // Streaming at full rate, then with a stalling sink
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, DATA_W'(32'h10000000 + i), 32'hA5A5A5A5, LEN'(i * 37), ADDR_WIDTH'(i));
      bus.chk_addr = ADDR_WIDTH'(i + 31);
      step();
    end
    for (int i = 0; i < 24; i++) begin
      set_in(i % 3 != 2, DATA_W'(32'h7F800001 + i * 4099), 32'h5A5A5A5A, LEN'(i * 101 + 1), ADDR_WIDTH'(i * 3));
      bus.out_ready = (i % 4) != 1;
      bus.chk_addr  = ADDR_WIDTH'(i * 3 - 3);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    step();
    check("final_empty", BUSW'(bus.count), BUSW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
